// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, error codes and FSM encoding shared by the execute-stage controller.
package cpu_pkg;
    localparam int DATA_W = 16;
    localparam logic [2:0] OP_ADD    = 3'b000;
    localparam logic [2:0] OP_SUB    = 3'b001;
    localparam logic [2:0] OP_MUL    = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b011;
    localparam logic [2:0] OP_LDI    = 3'b100;
    localparam logic [2:0] OP_ILL_LO = 3'b101;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_DIV0    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB} state_e;
    function automatic logic is_illegal(input logic [2:0] op);
        return op >= OP_ILL_LO;
    endfunction
endpackage

// File: rtl/regfile_8x16.sv
// regfile_8x16: register file with two combinational read ports, a debug read port
// and one synchronous write port; asynchronously cleared.
module regfile_8x16 #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr1_i,
    output logic [DATA_W-1:0] rdata1_o,
    input  logic [AW-1:0]     raddr2_i,
    output logic [DATA_W-1:0] rdata2_o,
    input  logic [AW-1:0]     dbg_addr_i,
    output logic [DATA_W-1:0] dbg_data_o
);
    logic [DATA_W-1:0] mem_q [NREGS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o   = mem_q[raddr1_i];
    assign rdata2_o   = mem_q[raddr2_i];
    assign dbg_data_o = mem_q[dbg_addr_i];
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: accepts one instruction at a time, issues it to alu_16 (or handles
// LDI locally), writes the result back and reports illegal-op, div-by-zero and timeout.
import cpu_pkg::*;

module alu_issue_ctrl #(
    parameter int DATA_W  = cpu_pkg::DATA_W,
    parameter int NREGS   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    output logic              alu_start,
    output logic [2:0]        alu_opcode,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_done,
    output logic              wb_valid,
    output logic [2:0]        wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              err_valid,
    output logic [1:0]        err_code,
    input  logic [2:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_e            state_q;
    logic [2:0]        rd_q;
    logic [CW-1:0]     cnt_q;
    logic              alu_start_q, wb_valid_q, err_valid_q;
    logic [2:0]        alu_opcode_q, wb_addr_q;
    logic [DATA_W-1:0] alu_a_q, alu_b_q, wb_data_q;
    logic [1:0]        err_code_q;
    logic [DATA_W-1:0] rs1_data, rs2_data, imm_ext;
    logic [2:0]        op;

    assign op      = instr[15:13];
    assign imm_ext = {{(DATA_W-10){instr[9]}}, instr[9:0]};

    // The file cannot change between accept and ISSUE, so operands are captured at accept.
    regfile_8x16 #(.DATA_W(DATA_W), .NREGS(NREGS)) u_rf (
        .clk       (clk),
        .reset     (reset),
        .we_i      (wb_valid_q),
        .waddr_i   (wb_addr_q),
        .wdata_i   (wb_data_q),
        .raddr1_i  (instr[9:7]),
        .rdata1_o  (rs1_data),
        .raddr2_i  (instr[6:4]),
        .rdata2_o  (rs2_data),
        .dbg_addr_i(dbg_addr),
        .dbg_data_o(dbg_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rd_q         <= '0;
            cnt_q        <= '0;
            alu_start_q  <= 1'b0;
            alu_opcode_q <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            wb_valid_q   <= 1'b0;
            wb_addr_q    <= '0;
            wb_data_q    <= '0;
            err_valid_q  <= 1'b0;
            err_code_q   <= '0;
        end else begin
            alu_start_q <= 1'b0;
            wb_valid_q  <= 1'b0;
            err_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: if (instr_valid) begin
                    rd_q <= instr[12:10];
                    if (is_illegal(op)) begin
                        err_valid_q <= 1'b1;
                        err_code_q  <= ERR_ILLEGAL;
                    end else if (op == OP_LDI) begin
                        state_q    <= S_WB;
                        wb_valid_q <= 1'b1;
                        wb_addr_q  <= instr[12:10];
                        wb_data_q  <= imm_ext;
                    end else if (op == OP_DIV && rs2_data == '0) begin
                        err_valid_q <= 1'b1;
                        err_code_q  <= ERR_DIV0;
                    end else begin
                        state_q      <= S_ISSUE;
                        alu_start_q  <= 1'b1;
                        alu_opcode_q <= op;
                        alu_a_q      <= rs1_data;
                        alu_b_q      <= rs2_data;
                    end
                end
                S_ISSUE: begin
                    state_q <= S_WAIT;
                    cnt_q   <= '0;
                end
                S_WAIT: if (alu_done) begin
                    state_q    <= S_WB;
                    wb_valid_q <= 1'b1;
                    wb_addr_q  <= rd_q;
                    wb_data_q  <= alu_result;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_q     <= S_IDLE;
                    err_valid_q <= 1'b1;
                    err_code_q  <= ERR_TIMEOUT;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                S_WB:    state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign instr_ready = state_q == S_IDLE;
    assign alu_start   = alu_start_q;
    assign alu_opcode  = alu_opcode_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign wb_valid    = wb_valid_q;
    assign wb_addr     = wb_addr_q;
    assign wb_data     = wb_data_q;
    assign err_valid   = err_valid_q;
    assign err_code    = err_code_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: table-driven scoreboard bench with a behavioural alu_16 stand-in
// that can be made to hang for the timeout case.
import cpu_pkg::*;

module tb_alu_issue_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [15:0] instr = '0;
    logic        alu_start;
    logic [2:0]  alu_opcode;
    logic [15:0] alu_a, alu_b, alu_result;
    logic        alu_done;
    logic        wb_valid, err_valid;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data, dbg_data;
    logic [1:0]  err_code;
    logic [2:0]  dbg_addr = '0;

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .alu_start(alu_start), .alu_opcode(alu_opcode), .alu_a(alu_a),
        .alu_b(alu_b), .alu_result(alu_result), .alu_done(alu_done), .wb_valid(wb_valid),
        .wb_addr(wb_addr), .wb_data(wb_data), .err_valid(err_valid), .err_code(err_code),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    int alu_lat = 2;
    bit alu_hang = 1'b0;
    int lat_cnt;

    function automatic logic [15:0] alu_f(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
        case (o)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_MUL:  return 16'($signed(a) * $signed(b));
            OP_DIV:  return (b == 16'd0) ? 16'd0 : 16'($signed(a) / $signed(b));
            default: return 16'd0;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_done   <= 1'b0;
            lat_cnt    <= 0;
            alu_result <= '0;
        end else if (alu_start) begin
            alu_done   <= 1'b0;
            lat_cnt    <= alu_lat;
            alu_result <= alu_f(alu_opcode, alu_a, alu_b);
        end else if (lat_cnt > 0) begin
            lat_cnt <= lat_cnt - 1;
            if (lat_cnt == 1 && !alu_hang) alu_done <= 1'b1;
        end
    end

    typedef struct {
        logic        is_err;
        logic [2:0]  addr;
        logic [15:0] data;
        logic [1:0]  code;
    } exp_t;

    typedef struct {
        logic [15:0] ins;
        logic        is_err;
        logic [1:0]  code;
        logic [15:0] data;
    } vec_t;

    exp_t        expq[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_start = 0;
    int          n_acc = 0;
    logic [15:0] model [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    always @(posedge clk) begin
        if (alu_start) n_start <= n_start + 1;
        if (instr_valid && instr_ready) n_acc <= n_acc + 1;
    end

    always @(negedge clk) begin
        if (!reset && (wb_valid || err_valid)) begin
            if (expq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pulse: got wb=%0b err=%0b, required none", wb_valid, err_valid);
            end else begin
                mon_e = expq.pop_front();
                chk("pulse_kind", {30'd0, wb_valid, err_valid}, mon_e.is_err ? 32'd1 : 32'd2);
                if (mon_e.is_err) chk("err_code", {30'd0, err_code}, {30'd0, mon_e.code});
                else begin
                    chk("wb_addr", {29'd0, wb_addr}, {29'd0, mon_e.addr});
                    chk("wb_data", {16'd0, wb_data}, {16'd0, mon_e.data});
                end
            end
        end
    end

    function automatic logic [15:0] rr(input logic [2:0] o, input logic [2:0] rd, input logic [2:0] s1, input logic [2:0] s2);
        return {o, rd, s1, s2, 4'b0};
    endfunction

    function automatic logic [15:0] ldi(input logic [2:0] rd, input logic [9:0] imm);
        return {OP_LDI, rd, imm};
    endfunction

    function automatic vec_t v(input logic [15:0] ins, input logic is_err, input logic [1:0] code, input logic [15:0] data);
        vec_t r;
        r.ins = ins; r.is_err = is_err; r.code = code; r.data = data;
        return r;
    endfunction

    function automatic exp_t wbx(input logic [2:0] a, input logic [15:0] d);
        exp_t e;
        e.is_err = 1'b0; e.addr = a; e.data = d; e.code = 2'b00;
        return e;
    endfunction

    function automatic exp_t errx(input logic [1:0] c);
        exp_t e;
        e.is_err = 1'b1; e.addr = 3'd0; e.data = 16'd0; e.code = c;
        return e;
    endfunction

    task automatic send(input logic [15:0] ins);
        int n = 0;
        @(negedge clk);
        instr_valid = 1'b1;
        instr = ins;
        while (!instr_ready && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) chk("accept_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1 instr_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        do begin @(negedge clk); n++; end
        while ((expq.size() != 0 || !instr_ready) && n < 300);
        if (n >= 300) chk("done_timeout", 32'(expq.size()), 32'd0);
    endtask

    task automatic check_regs(input string nm);
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1 chk(nm, {16'd0, dbg_data}, {16'd0, model[i]});
        end
    endtask

    vec_t vt[19];

    initial begin
        int s0, a0, n;
        vt[0]  = v(ldi(3'd1, 10'd100), 0, 2'b00, 16'd100);
        vt[1]  = v(ldi(3'd2, 10'h3F9), 0, 2'b00, 16'hFFF9);
        vt[2]  = v(rr(OP_ADD, 3'd3, 3'd1, 3'd2), 0, 2'b00, 16'd93);
        vt[3]  = v(rr(OP_SUB, 3'd4, 3'd1, 3'd2), 0, 2'b00, 16'd107);
        vt[4]  = v(ldi(3'd1, 10'd300), 0, 2'b00, 16'd300);
        vt[5]  = v(rr(OP_MUL, 3'd5, 3'd1, 3'd1), 0, 2'b00, 16'd24464);
        vt[6]  = v(rr(OP_DIV, 3'd6, 3'd2, 3'd1), 0, 2'b00, 16'd0);
        vt[7]  = v(ldi(3'd7, 10'd0), 0, 2'b00, 16'd0);
        vt[8]  = v(rr(OP_DIV, 3'd0, 3'd1, 3'd7), 1, ERR_DIV0, 16'd0);
        vt[9]  = v(16'hC000, 1, ERR_ILLEGAL, 16'd0);
        vt[10] = v(ldi(3'd0, 10'h200), 0, 2'b00, 16'hFE00);
        vt[11] = v(ldi(3'd1, 10'h1FF), 0, 2'b00, 16'd511);
        vt[12] = v(rr(OP_ADD, 3'd1, 3'd1, 3'd1), 0, 2'b00, 16'd1022);
        vt[13] = v(rr(OP_SUB, 3'd2, 3'd2, 3'd1), 0, 2'b00, 16'hFBFB);
        vt[14] = v(rr(OP_DIV, 3'd3, 3'd2, 3'd0), 0, 2'b00, 16'd2);
        vt[15] = v(rr(OP_MUL, 3'd4, 3'd2, 3'd0), 0, 2'b00, 16'h0A00);
        vt[16] = v(16'hE3F0, 1, ERR_ILLEGAL, 16'd0);
        vt[17] = v(rr(OP_DIV, 3'd5, 3'd4, 3'd2), 0, 2'b00, 16'hFFFE);
        vt[18] = v(rr(OP_SUB, 3'd6, 3'd0, 3'd1), 0, 2'b00, 16'hFA02);
        for (int i = 0; i < 8; i++) model[i] = 16'd0;

        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, instr_ready}, 32'd1);
        chk("rst_start", {31'd0, alu_start}, 32'd0);
        chk("rst_pulses", {30'd0, wb_valid, err_valid}, 32'd0);
        chk("rst_alu_out", {13'd0, alu_opcode, alu_a}, 32'd0);
        check_regs("rst_regs");
        reset = 1'b0;

        for (int i = 0; i < 19; i++) begin
            expq.push_back(vt[i].is_err ? errx(vt[i].code) : wbx(vt[i].ins[12:10], vt[i].data));
            send(vt[i].ins);
            wait_done();
            if (!vt[i].is_err) model[vt[i].ins[12:10]] = vt[i].data;
        end
        check_regs("table_regs");

        expq.push_back(wbx(3'd2, 16'd5));
        send(ldi(3'd2, 10'd5));
        @(negedge clk);
        chk("ldi_latency", {31'd0, wb_valid}, 32'd1);
        wait_done();
        model[2] = 16'd5;

        s0 = n_start;
        expq.push_back(errx(ERR_DIV0));
        send(rr(OP_DIV, 3'd5, 3'd5, 3'd7));
        wait_done();
        chk("div0_no_start", 32'(n_start - s0), 32'd0);
        dbg_addr = 3'd5;
        #1 chk("div0_rd_kept", {16'd0, dbg_data}, {16'd0, model[5]});

        a0 = n_acc;
        expq.push_back(wbx(3'd7, 16'h01FE));
        @(negedge clk);
        instr_valid = 1'b1;
        instr = rr(OP_ADD, 3'd7, 3'd0, 3'd1);
        @(posedge clk);
        #1 instr = 16'hC000;
        n = 0;
        do begin @(negedge clk); n++; end while (!instr_ready && n < 200);
        instr_valid = 1'b0;
        wait_done();
        chk("hold_one_accept", 32'(n_acc - a0), 32'd1);
        model[7] = 16'h01FE;
        check_regs("post_regs");

        alu_hang = 1'b1;
        expq.push_back(errx(ERR_TIMEOUT));
        send(rr(OP_ADD, 3'd1, 3'd1, 3'd1));
        n = 0;
        do begin @(negedge clk); n++; end while (!err_valid && n < 200);
        chk("timeout_cycles", 32'(n), 32'd66);
        wait_done();
        dbg_addr = 3'd1;
        #1 chk("timeout_no_write", {16'd0, dbg_data}, {16'd0, model[1]});

        send(rr(OP_ADD, 3'd3, 3'd1, 3'd2));
        repeat (5) @(negedge clk);
        chk("wait_busy", {31'd0, instr_ready}, 32'd0);
        #2 reset = 1'b1;
        #1 chk("arst_ready", {31'd0, instr_ready}, 32'd1);
        chk("arst_start", {31'd0, alu_start}, 32'd0);
        for (int i = 0; i < 8; i++) model[i] = 16'd0;
        check_regs("arst_regs");
        @(negedge clk);
        reset = 1'b0;
        alu_hang = 1'b0;
        repeat (3) @(negedge clk);
        chk("arst_no_pulse", 32'(expq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, required finish");
        $fatal(1);
    end
endmodule
